// File: rtl/pipe_hazard_ctrl.sv
// Y86 five-stage pipeline control: stall/bubble generation, post-reset flush
// sequencing, exception freeze and saturating performance counters.
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYC = 5,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [3:0]       M_icode,
    input  logic [2:0]       m_stat,
    input  logic [2:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             set_cc,
    output logic             halted,
    output logic [2:0]       halt_stat,
    output logic [CNT_W-1:0] load_use_cnt,
    output logic [CNT_W-1:0] mispred_cnt,
    output logic [CNT_W-1:0] ret_cnt,
    output logic [CNT_W-1:0] run_cycles
);

    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_IRET   = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] R_NONE   = 4'hF;

    localparam int              FC_W    = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FLUSH_CYC - 1);

    typedef enum logic [1:0] {S_FLUSH, S_RUN, S_HALTED} state_t;

    state_t           state_q, state_d;
    logic [FC_W-1:0]  fcnt_q, fcnt_d;
    logic [2:0]       hstat_q, hstat_d;
    logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
    logic [CNT_W-1:0] mp_cnt_q, mp_cnt_d;
    logic [CNT_W-1:0] rt_cnt_q, rt_cnt_d;
    logic [CNT_W-1:0] run_q, run_d;

    // case-based matching so X/Z inputs from bubbles never match a constant
    function automatic logic eq4(input logic [3:0] a, input logic [3:0] b);
        case (a)
            b:       eq4 = 1'b1;
            default: eq4 = 1'b0;
        endcase
    endfunction

    function automatic logic is_exc(input logic [2:0] s);
        case (s)
            3'd2, 3'd3, 3'd4: is_exc = 1'b1;
            default:          is_exc = 1'b0;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != {CNT_W{1'b1}})) sat_inc = v + 1'b1;
        else                            sat_inc = v;
    endfunction

    logic lu, mp, rt, m_exc, w_exc;

    always_comb begin
        lu    = (eq4(E_icode, I_MRMOVQ) || eq4(E_icode, I_POPQ)) && !eq4(E_dstM, R_NONE) &&
                (eq4(E_dstM, d_srcA) || eq4(E_dstM, d_srcB));
        mp    = eq4(E_icode, I_JXX) && !e_Cnd;
        rt    = eq4(D_icode, I_IRET) || eq4(E_icode, I_IRET) || eq4(M_icode, I_IRET);
        m_exc = is_exc(m_stat);
        w_exc = is_exc(W_stat);
    end

    // outputs: FLUSH pattern is the default so reset forces it asynchronously
    always_comb begin
        F_stall  = 1'b1;
        D_stall  = 1'b0;
        D_bubble = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
        W_stall  = 1'b0;
        set_cc   = 1'b0;
        halted   = 1'b0;
        case (state_q)
            S_RUN: begin
                F_stall  = lu || rt;
                D_stall  = lu;
                D_bubble = mp || (!lu && rt);
                E_bubble = mp || lu;
                M_bubble = m_exc || w_exc;
                W_stall  = w_exc;
                set_cc   = eq4(E_icode, I_OPQ) && !m_exc && !w_exc;
            end
            S_HALTED: begin
                D_stall  = 1'b1;
                D_bubble = 1'b0;
                W_stall  = 1'b1;
                halted   = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        hstat_d  = hstat_q;
        lu_cnt_d = lu_cnt_q;
        mp_cnt_d = mp_cnt_q;
        rt_cnt_d = rt_cnt_q;
        run_d    = run_q;
        case (state_q)
            S_FLUSH: begin
                fcnt_d = fcnt_q + 1'b1;
                if (fcnt_q == FC_LAST) state_d = S_RUN;
            end
            S_RUN: begin
                lu_cnt_d = sat_inc(lu_cnt_q, lu);
                mp_cnt_d = sat_inc(mp_cnt_q, mp);
                // a ret is bubbled out of D, so it is seen in D exactly once unless held by lu
                rt_cnt_d = sat_inc(rt_cnt_q, eq4(D_icode, I_IRET) && !lu);
                run_d    = sat_inc(run_q, 1'b1);
                if (w_exc) begin
                    state_d = S_HALTED;
                    hstat_d = W_stat;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_FLUSH;
            fcnt_q   <= '0;
            hstat_q  <= '0;
            lu_cnt_q <= '0;
            mp_cnt_q <= '0;
            rt_cnt_q <= '0;
            run_q    <= '0;
        end else begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            hstat_q  <= hstat_d;
            lu_cnt_q <= lu_cnt_d;
            mp_cnt_q <= mp_cnt_d;
            rt_cnt_q <= rt_cnt_d;
            run_q    <= run_d;
        end
    end

    assign halt_stat    = hstat_q;
    assign load_use_cnt = lu_cnt_q;
    assign mispred_cnt  = mp_cnt_q;
    assign ret_cnt      = rt_cnt_q;
    assign run_cycles   = run_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl against a cycle-level reference model;
// a second instance with 4-bit counters exercises saturation.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
    logic       e_Cnd;
    logic [2:0] m_stat, W_stat;

    logic F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted;
    logic [2:0]  halt_stat;
    logic [31:0] lu_a, mp_a, rt_a, run_a;
    logic b_F_stall, b_D_stall, b_D_bubble, b_E_bubble, b_M_bubble, b_W_stall, b_set_cc, b_halted;
    logic [2:0]  b_halt_stat;
    logic [3:0]  lu_b, mp_b, rt_b, run_b;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.FLUSH_CYC(5), .CNT_W(32)) u_a (
        .clk(clk), .rst_n(rst_n), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
        .m_stat(m_stat), .W_stat(W_stat), .F_stall(F_stall), .D_stall(D_stall),
        .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
        .set_cc(set_cc), .halted(halted), .halt_stat(halt_stat), .load_use_cnt(lu_a),
        .mispred_cnt(mp_a), .ret_cnt(rt_a), .run_cycles(run_a));

    pipe_hazard_ctrl #(.FLUSH_CYC(5), .CNT_W(4)) u_b (
        .clk(clk), .rst_n(rst_n), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
        .m_stat(m_stat), .W_stat(W_stat), .F_stall(b_F_stall), .D_stall(b_D_stall),
        .D_bubble(b_D_bubble), .E_bubble(b_E_bubble), .M_bubble(b_M_bubble), .W_stall(b_W_stall),
        .set_cc(b_set_cc), .halted(b_halted), .halt_stat(b_halt_stat), .load_use_cnt(lu_b),
        .mispred_cnt(mp_b), .ret_cnt(rt_b), .run_cycles(run_b));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    // reference model: 0 = flushing, 1 = running, 2 = frozen
    int     mode;
    int     flush_left;
    int     m_hstat;
    longint c32[4];  // 0 lu, 1 mp, 2 ret, 3 run
    int     c4[4];

    function automatic bit exc(input logic [2:0] s);
        return (s >= 3'd2) && (s <= 3'd4);
    endfunction

    function automatic bit hz_lu();
        return (E_icode == 4'h5 || E_icode == 4'hB) && E_dstM != 4'hF &&
               (E_dstM == d_srcA || E_dstM == d_srcB);
    endfunction

    function automatic bit hz_mp();
        return E_icode == 4'h7 && !e_Cnd;
    endfunction

    function automatic bit hz_rt();
        return D_icode == 4'h9 || E_icode == 4'h9 || M_icode == 4'h9;
    endfunction

    // {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted}
    function automatic logic [7:0] exp_ctl();
        bit lu, mp, rt;
        lu = hz_lu(); mp = hz_mp(); rt = hz_rt();
        if (mode == 0) return 8'b1011_1000;
        if (mode == 2) return 8'b1101_1101;
        return {lu | rt, lu, mp | (!lu & rt), mp | lu, exc(m_stat) | exc(W_stat), exc(W_stat),
                E_icode == 4'h6 && !exc(m_stat) && !exc(W_stat), 1'b0};
    endfunction

    task automatic model_reset();
        mode = 0; flush_left = 5; m_hstat = 0;
        for (int i = 0; i < 4; i++) begin c32[i] = 0; c4[i] = 0; end
    endtask

    task automatic bump(input int i, input bit en);
        if (en) begin
            if (c32[i] < 64'hFFFF_FFFF) c32[i]++;
            if (c4[i] < 15) c4[i]++;
        end
    endtask

    task automatic model_clk();
        bit lu;
        if (mode == 0) begin
            flush_left--;
            if (flush_left == 0) mode = 1;
        end else if (mode == 1) begin
            lu = hz_lu();
            bump(0, lu);
            bump(1, hz_mp());
            bump(2, D_icode == 4'h9 && !lu);
            bump(3, 1'b1);
            if (exc(W_stat)) begin mode = 2; m_hstat = W_stat; end
        end
    endtask

    task automatic check_all();
        chk("ctl", {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted}, exp_ctl());
        chk("b_ctl", {b_F_stall, b_D_stall, b_D_bubble, b_E_bubble, b_M_bubble, b_W_stall, b_set_cc, b_halted}, exp_ctl());
        chk("halt_stat", halt_stat, m_hstat);
        chk("lu32", lu_a, c32[0]);  chk("mp32", mp_a, c32[1]);
        chk("rt32", rt_a, c32[2]);  chk("run32", run_a, c32[3]);
        chk("lu4", lu_b, c4[0]);    chk("mp4", mp_b, c4[1]);
        chk("rt4", rt_b, c4[2]);    chk("run4", run_b, c4[3]);
    endtask

    // called just after a posedge; checks at negedge, advances model at the next posedge
    task automatic step();
        @(negedge clk);
        check_all();
        @(posedge clk);
        if (rst_n) model_clk();
        #1;
    endtask

    task automatic quiet();
        D_icode = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF; E_icode = 4'h1; E_dstM = 4'hF;
        e_Cnd = 1'b1; M_icode = 4'h1; m_stat = 3'd1; W_stat = 3'd1;
    endtask

    // asynchronous reset taken mid-cycle; outputs must react before any edge
    task automatic reset_dut();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_ctl", {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted}, 8'b1011_1000);
        chk("rst_cnt", {lu_a, mp_a, rt_a, run_a}, 0);
        chk("rst_hstat", halt_stat, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic run_flush();
        int n = 0;
        quiet();
        while (F_stall && n < 20) begin step(); n++; end
        chk("flush_len", n, 5);
    endtask

    function automatic logic [3:0] r_icode();
        case ($urandom_range(0, 7))
            0: return 4'h5;
            1: return 4'hB;
            2: return 4'h6;
            3: return 4'h7;
            4: return 4'h9;
            5: return 4'h1;
            default: return 4'($urandom_range(0, 15));
        endcase
    endfunction

    function automatic logic [3:0] r_reg();
        return ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 3));
    endfunction

    function automatic logic [2:0] r_stat(input int rarity);
        if ($urandom_range(0, rarity) != 0) return 3'd1;
        return 3'($urandom_range(0, 7));
    endfunction

    initial begin
        quiet();
        model_reset();
        @(posedge clk);
        reset_dut();
        run_flush();

        // load-use, then same with no destination
        E_icode = 4'h5; E_dstM = 4'h3; d_srcB = 4'h3;
        step();
        chk("lu_once", lu_a, 1);
        E_dstM = 4'hF;
        step();
        quiet();
        // mispredict, then taken branch
        E_icode = 4'h7; e_Cnd = 1'b0; step();
        chk("mp_once", mp_a, 1);
        e_Cnd = 1'b1; step();
        // ret walking D->E->M
        quiet(); D_icode = 4'h9; step();
        quiet(); E_icode = 4'h9; step();
        quiet(); M_icode = 4'h9; step();
        chk("ret_once", rt_a, 1);
        // ret with concurrent load-use while in D (held one extra cycle)
        quiet(); D_icode = 4'h9; E_icode = 4'h5; E_dstM = 4'h2; d_srcA = 4'h2; step();
        quiet(); D_icode = 4'h9; step();
        quiet(); E_icode = 4'h9; step();
        quiet(); M_icode = 4'h9; step();
        chk("ret_lu", rt_a, 2);
        // exception reaching M then W
        quiet(); E_icode = 4'h6; m_stat = 3'd3; step();
        quiet(); W_stat = 3'd3; step();
        quiet(); W_stat = 3'd4; step();
        chk("halt_hold", halt_stat, 3);
        chk("halted", halted, 1);
        W_stat = 3'd2; step();

        // saturation of the 4-bit instance under sustained load-use
        reset_dut();
        run_flush();
        E_icode = 4'hB; E_dstM = 4'h1; d_srcA = 4'h1;
        repeat (20) step();
        chk("sat_lu4", lu_b, 15);
        chk("sat_lu32", lu_a, 20);
        reset_dut();
        run_flush();

        // randomized traffic with occasional exceptions and async resets
        for (int i = 0; i < 3000; i++) begin
            D_icode = r_icode(); E_icode = r_icode(); M_icode = r_icode();
            d_srcA = r_reg(); d_srcB = r_reg(); E_dstM = r_reg();
            e_Cnd = 1'($urandom_range(0, 1));
            m_stat = r_stat(15);
            W_stat = r_stat(60);
            if ($urandom_range(0, 99) == 0) reset_dut();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
